irq_edge_collector: RTL and testbench

- Sequential front end for the 4-input priority encoder.
- Takes four asynchronous request lines D0..D3 (D3 highest priority) and synchronises them.
- Captures rising edges into sticky pending bits.
- Offers the highest-priority unmasked pending request as a 2-bit code with a valid/ready handshake.
- Clears each pending bit only when its offer is accepted, so no request edge is lost while the consumer is busy.

---
 rtl/irq_edge_collector.sv | 66 ++++++
 tb/tb_irq_edge_collector.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_edge_collector.sv
// irq_edge_collector: synchronises four async request lines, latches their rising edges as sticky
// pending bits and offers the highest-priority unmasked one over a valid/ready handshake.
module irq_edge_collector #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  output logic       out_valid,
  output logic [1:0] out_code,
  input  logic       out_ready,
  output logic [3:0] pending,
  output logic [3:0] overflow,
  input  logic       clr_ovf
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0] hist_q, hist_d, pending_q, pending_d, overflow_q, overflow_d;
  logic [3:0] sreq, rise, clr, elig;
  logic [1:0] code_q, code_d, top;
  logic fire;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req};
    sreq = sync_q[SYNC_STAGES-1];
    hist_d = sreq;
    rise = sreq & ~hist_q;
    fire = (state_q == OFFER) && out_ready;
    clr = fire ? 4'b0001 << code_q : 4'b0000;
    // a rise on the line being cleared re-arms it instead of counting as overflow
    pending_d = (pending_q & ~clr) | rise;
    overflow_d = (clr_ovf ? 4'b0000 : overflow_q) | (rise & pending_q & ~clr);
    elig = pending_q & ~mask;
    top = elig[3] ? 2'd3 : elig[2] ? 2'd2 : elig[1] ? 2'd1 : 2'd0;
    state_d = state_q;
    code_d = code_q;
    if (state_q == IDLE && elig != 4'b0000) begin
      state_d = OFFER;
      code_d = top;
    end else if (fire) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
      pending_q <= '0;
      overflow_q <= '0;
      state_q <= IDLE;
      code_q <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      pending_q <= pending_d;
      overflow_q <= overflow_d;
      state_q <= state_d;
      code_q <= code_d;
    end
  end
  assign out_valid = (state_q == OFFER);
  assign out_code = code_q;
  assign pending = pending_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_irq_edge_collector.sv
// tb_irq_edge_collector: vector table, directed corner sequences and random traffic checked
// against a cycle-level reference model of the collector.
module tb_irq_edge_collector;
  localparam int S = 2;
  logic clk = 0, rst_n = 0, out_ready = 0, clr_ovf = 0;
  logic [3:0] req = 0, mask = 0;
  logic out_valid;
  logic [1:0] out_code;
  logic [3:0] pending, overflow;
  int n_chk = 0, n_fail = 0;

  irq_edge_collector #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .out_valid(out_valid),
    .out_code(out_code), .out_ready(out_ready), .pending(pending),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // reference model: history of sampled req values, newest first
  bit [3:0] mq[$];
  bit m_off;
  int m_code;
  bit [3:0] m_pend, m_ovf;

  task automatic m_reset();
    mq = {};
    repeat (S + 1) mq.push_back(4'b0);
    m_off = 0;
    m_code = 0;
    m_pend = 0;
    m_ovf = 0;
  endtask

  task automatic m_step();
    bit [3:0] rise, clr, elig;
    rise = mq[S-1] & ~mq[S];
    clr = (m_off && out_ready) ? 4'(1 << m_code) : 4'b0;
    elig = m_pend & ~mask;
    m_ovf = (clr_ovf ? 4'b0 : m_ovf) | (rise & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | rise;
    if (m_off) begin
      if (out_ready) m_off = 0;
    end else if (elig != 0) begin
      m_off = 1;
      for (int i = 0; i < 4; i++) if (elig[i]) m_code = i;
    end
    mq.push_front(req);
    void'(mq.pop_back());
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_step();
    #1;
    chk("model valid", out_valid, m_off);
    chk("model code", out_code, m_code);
    chk("model pending", pending, m_pend);
    chk("model overflow", overflow, m_ovf);
  endtask

  task automatic wait_offer(input string name);
    int n = 0;
    while (!out_valid && n < 12) begin
      step();
      n++;
    end
    chk({name, " offer seen"}, out_valid, 1);
  endtask

  task automatic accept();
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  typedef struct {
    logic [3:0] req;
    logic rdy;
    logic exp_v;
    logic [1:0] exp_code;
    logic [3:0] exp_pend;
  } vec_t;
  vec_t tbl[7];
  int fires;

  initial begin
    tbl[0] = '{4'b0100, 1, 0, 2'd0, 4'b0000};
    tbl[1] = '{4'b0100, 1, 0, 2'd0, 4'b0000};
    tbl[2] = '{4'b0100, 1, 0, 2'd0, 4'b0100};
    tbl[3] = '{4'b0100, 1, 1, 2'd2, 4'b0100};
    tbl[4] = '{4'b0100, 1, 0, 2'd2, 4'b0000};
    tbl[5] = '{4'b0100, 1, 0, 2'd2, 4'b0000};
    tbl[6] = '{4'b0000, 1, 0, 2'd2, 4'b0000};
    m_reset();
    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", out_valid, 0);
    chk("reset code", out_code, 0);
    chk("reset pending", pending, 0);
    chk("reset overflow", overflow, 0);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle valid", out_valid, 0);
    end
    // single request, vector table
    for (int i = 0; i < 7; i++) begin
      req = tbl[i].req;
      out_ready = tbl[i].rdy;
      step();
      chk("tbl valid", out_valid, tbl[i].exp_v);
      chk("tbl code", out_code, tbl[i].exp_code);
      chk("tbl pending", pending, tbl[i].exp_pend);
    end
    out_ready = 0;
    repeat (4) step();
    // priority and hold
    req = 4'b0011;
    wait_offer("prio1");
    chk("prio first code", out_code, 1);
    req = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("prio hold code", out_code, 1);
      chk("prio hold valid", out_valid, 1);
    end
    accept();
    wait_offer("prio3");
    chk("prio second code", out_code, 3);
    accept();
    wait_offer("prio0");
    chk("prio third code", out_code, 0);
    accept();
    req = 0;
    repeat (5) step();
    chk("prio drained", pending, 0);
    // masking
    mask = 4'b1000;
    req = 4'b1000;
    repeat (3) step();
    req = 0;
    step();
    req = 4'b0010;
    repeat (3) step();
    req = 0;
    wait_offer("mask1");
    chk("mask code", out_code, 1);
    chk("mask pend3", pending[3], 1);
    accept();
    repeat (3) step();
    chk("mask blocked", out_valid, 0);
    mask = 0;
    wait_offer("mask3");
    chk("unmask code", out_code, 3);
    accept();
    repeat (3) step();
    // overflow
    for (int k = 0; k < 2; k++) begin
      req = 4'b0100;
      repeat (3) step();
      req = 0;
      repeat (4) step();
    end
    chk("ovf overflow", overflow, 4'b0100);
    chk("ovf pending", pending, 4'b0100);
    clr_ovf = 1;
    step();
    clr_ovf = 0;
    chk("ovf cleared", overflow, 0);
    fires = 0;
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        fires++;
        chk("ovf offer code", out_code, 2);
      end
      step();
    end
    out_ready = 0;
    chk("ovf single offer", fires, 1);
    // clear/set collision
    req = 4'b0010;
    wait_offer("coll first");
    chk("coll first code", out_code, 1);
    req = 0;
    repeat (4) step();
    req = 4'b0010;
    step();
    step();
    out_ready = 1;
    step();
    out_ready = 0;
    chk("coll pend1 kept", pending[1], 1);
    chk("coll no ovf", overflow[1], 0);
    wait_offer("coll second");
    chk("coll second code", out_code, 1);
    // reset while offering, req[0] held through release
    req = 4'b0001;
    #2;
    rst_n = 0;
    #1;
    m_reset();
    chk("midrst valid", out_valid, 0);
    chk("midrst pending", pending, 0);
    chk("midrst code", out_code, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (3) step();
    chk("rst latency early", out_valid, 0);
    step();
    chk("rst latency valid", out_valid, 1);
    chk("rst latency code", out_code, 0);
    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      if (i % 16 == 0) mask = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      clr_ovf = ($urandom_range(0, 15) == 0);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
